// File: rtl/clk_rst_sequencer.sv
// -----------------------------------------------------------------------------
// clk_rst_sequencer
//
// Brings the core out of reset once the PLL has been locked and stable, then
// generates the divided clock enables used by the video, CPU and sound blocks.
//
// Sequence: WAIT_LOCK -> STABILIZE (STABLE_CYCLES of continuous lock)
//           -> RESET_HOLD (RESET_CYCLES of sys_rst) -> RUN.
// Lock loss in any state returns to WAIT_LOCK. soft_reset re-runs RESET_HOLD.
//
// Ports:
//   clk         in   single 42.954540 MHz PLL clock, rising-edge logic
//   rst         in   asynchronous active-high reset
//   pll_locked  in   PLL lock flag, asynchronous to clk (double-synchronized)
//   soft_reset  in   synchronous request to re-run RESET_HOLD
//   pause       in   synchronous, suppresses ce_cpu only
//   sys_rst     out  registered core reset, high whenever state != RUN
//   ce_vdp      out  registered clk/4 enable
//   ce_cpu      out  registered clk/12 enable (dropped while paused)
//   ce_psg      out  registered clk/24 enable
//   state       out  0 WAIT_LOCK, 1 STABILIZE, 2 RESET_HOLD, 3 RUN
// -----------------------------------------------------------------------------
module clk_rst_sequencer #(
   parameter int STABLE_CYCLES = 1024,
   parameter int RESET_CYCLES  = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pll_locked,
   input  logic       soft_reset,
   input  logic       pause,
   output logic       sys_rst,
   output logic       ce_vdp,
   output logic       ce_cpu,
   output logic       ce_psg,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      ST_WAIT_LOCK  = 2'd0,
      ST_STABILIZE  = 2'd1,
      ST_RESET_HOLD = 2'd2,
      ST_RUN        = 2'd3
   } state_t;

   // Terminal counts: the counter reaches *_LAST on the final cycle of a phase,
   // so the phase lasts exactly N cycles and the counter never wraps.
   localparam logic [15:0] STABLE_LAST = 16'(STABLE_CYCLES - 1);
   localparam logic [15:0] RESET_LAST  = 16'(RESET_CYCLES - 1);
   localparam logic [4:0]  PH_LAST     = 5'd23;

   logic [1:0]  lock_sync_r;
   logic        locked_s;
   state_t      state_r;
   state_t      state_s;
   logic [15:0] cnt_r;
   logic [15:0] cnt_s;
   logic [4:0]  ph_r;
   logic [4:0]  ph_s;
   logic        sys_rst_r;
   logic        sys_rst_s;
   logic        ce_vdp_r;
   logic        ce_vdp_s;
   logic        ce_cpu_r;
   logic        ce_cpu_s;
   logic        ce_psg_r;
   logic        ce_psg_s;

   assign locked_s = lock_sync_r[1];

   // Two-flop synchronizer for the asynchronous PLL lock flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lock_sync_r <= 2'b00;
      end else begin
         lock_sync_r <= {lock_sync_r[0], pll_locked};
      end
   end

   // State register: FSM state, shared phase counter and RUN phase counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_WAIT_LOCK;
         cnt_r   <= 16'd0;
         ph_r    <= 5'd0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         ph_r    <= ph_s;
      end
   end

   // Next-state logic. Lock loss is checked first in every state so it wins
   // over soft_reset and over counter expiry in the same cycle.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      case (state_r)
         ST_WAIT_LOCK: begin
            cnt_s = 16'd0;
            if (locked_s) begin
               state_s = ST_STABILIZE;
            end else begin
               state_s = ST_WAIT_LOCK;
            end
         end
         ST_STABILIZE: begin
            if (!locked_s) begin
               state_s = ST_WAIT_LOCK;
               cnt_s   = 16'd0;
            end else if (cnt_r == STABLE_LAST) begin
               state_s = ST_RESET_HOLD;
               cnt_s   = 16'd0;
            end else begin
               cnt_s   = cnt_r + 16'd1;
            end
         end
         ST_RESET_HOLD: begin
            if (!locked_s) begin
               state_s = ST_WAIT_LOCK;
               cnt_s   = 16'd0;
            end else if (soft_reset) begin
               // Restart the hold window from its first cycle.
               state_s = ST_RESET_HOLD;
               cnt_s   = 16'd0;
            end else if (cnt_r == RESET_LAST) begin
               state_s = ST_RUN;
               cnt_s   = 16'd0;
            end else begin
               cnt_s   = cnt_r + 16'd1;
            end
         end
         ST_RUN: begin
            cnt_s = 16'd0;
            if (!locked_s) begin
               state_s = ST_WAIT_LOCK;
            end else if (soft_reset) begin
               state_s = ST_RESET_HOLD;
            end else begin
               state_s = ST_RUN;
            end
         end
         default: begin
            state_s = ST_WAIT_LOCK;
            cnt_s   = 16'd0;
         end
      endcase
   end

   // Output logic: decode the *next* phase so the registered enables line up
   // with the registered phase and state in the same cycle.
   always_comb begin
      ph_s      = 5'd0;
      sys_rst_s = 1'b1;
      ce_vdp_s  = 1'b0;
      ce_cpu_s  = 1'b0;
      ce_psg_s  = 1'b0;
      if (state_s == ST_RUN) begin
         sys_rst_s = 1'b0;
         // First RUN cycle starts at phase 0; afterwards count 0..23.
         if (state_r == ST_RUN) begin
            if (ph_r == PH_LAST) begin
               ph_s = 5'd0;
            end else begin
               ph_s = ph_r + 5'd1;
            end
         end else begin
            ph_s = 5'd0;
         end
         // Phases 3,7,...,23 are exactly those with low bits 2'b11.
         ce_vdp_s = (ph_s[1:0] == 2'b11);
         ce_cpu_s = ((ph_s == 5'd11) || (ph_s == PH_LAST)) && !pause;
         ce_psg_s = (ph_s == PH_LAST);
      end else begin
         ph_s      = 5'd0;
         sys_rst_s = 1'b1;
      end
   end

   // Output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sys_rst_r <= 1'b1;
         ce_vdp_r  <= 1'b0;
         ce_cpu_r  <= 1'b0;
         ce_psg_r  <= 1'b0;
      end else begin
         sys_rst_r <= sys_rst_s;
         ce_vdp_r  <= ce_vdp_s;
         ce_cpu_r  <= ce_cpu_s;
         ce_psg_r  <= ce_psg_s;
      end
   end

   assign sys_rst = sys_rst_r;
   assign ce_vdp  = ce_vdp_r;
   assign ce_cpu  = ce_cpu_r;
   assign ce_psg  = ce_psg_r;
   assign state   = state_r;

endmodule

// File: tb/tb_clk_rst_sequencer.sv
module tb_clk_rst_sequencer;

   logic       clk;
   logic       rst;
   logic       pll_locked;
   logic       soft_reset;
   logic       pause;
   logic       sys_rst;
   logic       ce_vdp;
   logic       ce_cpu;
   logic       ce_psg;
   logic [1:0] state;

   int errors;
   int checks;

   clk_rst_sequencer #(
      .STABLE_CYCLES(8),
      .RESET_CYCLES (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .pll_locked (pll_locked),
      .soft_reset (soft_reset),
      .pause      (pause),
      .sys_rst    (sys_rst),
      .ce_vdp     (ce_vdp),
      .ce_cpu     (ce_cpu),
      .ce_psg     (ce_psg),
      .state      (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // advance one rising edge and sample 1 ns later
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; pll_locked = 1'b0; soft_reset = 1'b0; pause = 1'b0;
      repeat (3) tick();
      checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
      checks++; if (sys_rst !== 1'b1) begin errors++; $display("FAIL reset_sys_rst: got %b want 1", sys_rst); end
      checks++; if ({ce_vdp, ce_cpu, ce_psg} !== 3'b000) begin errors++; $display("FAIL reset_enables: got %b want 000", {ce_vdp, ce_cpu, ce_psg}); end
   endtask

   // rst must be high on entry; lock is applied, rst released, edge 0 follows
   task automatic test_power_up(input string tag);
      int fv, fc, fp;
      fv = -1; fc = -1; fp = -1;
      pll_locked = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int e = 0; e <= 40; e++) begin
         tick();
         if (e == 1 && state !== 2'd0) begin errors++; $display("FAIL %s_state_e1: got %0d want 0", tag, state); end
         if (e == 2 && state !== 2'd1) begin errors++; $display("FAIL %s_state_e2: got %0d want 1", tag, state); end
         if (e == 9 && state !== 2'd1) begin errors++; $display("FAIL %s_state_e9: got %0d want 1", tag, state); end
         if (e == 10 && state !== 2'd2) begin errors++; $display("FAIL %s_state_e10: got %0d want 2", tag, state); end
         if (e == 13 && (state !== 2'd2 || sys_rst !== 1'b1)) begin errors++; $display("FAIL %s_e13: got state %0d sys_rst %b want 2/1", tag, state, sys_rst); end
         if (e == 14 && (state !== 2'd3 || sys_rst !== 1'b0)) begin errors++; $display("FAIL %s_e14: got state %0d sys_rst %b want 3/0", tag, state, sys_rst); end
         if (e == 1 || e == 2 || e == 9 || e == 10 || e == 13 || e == 14) checks++;
         if (ce_vdp === 1'b1 && fv < 0) fv = e;
         if (ce_cpu === 1'b1 && fc < 0) fc = e;
         if (ce_psg === 1'b1 && fp < 0) fp = e;
      end
      checks++; if (fv != 17) begin errors++; $display("FAIL %s_first_vdp: got edge %0d want 17", tag, fv); end
      checks++; if (fc != 25) begin errors++; $display("FAIL %s_first_cpu: got edge %0d want 25", tag, fc); end
      checks++; if (fp != 37) begin errors++; $display("FAIL %s_first_psg: got edge %0d want 37", tag, fp); end
   endtask

   // returns with the sample of a ce_psg cycle (ph=23)
   task automatic sync_psg(input string tag);
      int n;
      n = 0;
      tick();
      while (ce_psg !== 1'b1 && n < 40) begin tick(); n++; end
      checks++; if (ce_psg !== 1'b1) begin errors++; $display("FAIL %s_sync_timeout: ce_psg got %b want 1", tag, ce_psg); end
   endtask

   task automatic test_pause;
      sync_psg("pause");
      for (int k = 1; k <= 24; k++) begin
         tick();
         if (k == 10) pause = 1'b1;
         if (k == 12) begin
            checks++; if (ce_vdp !== 1'b1) begin errors++; $display("FAIL pause_vdp_ph11: got %b want 1", ce_vdp); end
            checks++; if (ce_cpu !== 1'b0) begin errors++; $display("FAIL pause_cpu_ph11: got %b want 0", ce_cpu); end
            pause = 1'b0;
         end
         if (k == 13) begin
            checks++; if (ce_cpu !== 1'b0) begin errors++; $display("FAIL pause_not_deferred: got %b want 0", ce_cpu); end
         end
         if (k == 24) begin
            checks++; if ({ce_cpu, ce_psg} !== 2'b11) begin errors++; $display("FAIL pause_cpu_ph23: got %b want 11", {ce_cpu, ce_psg}); end
         end
      end
   endtask

   task automatic test_soft_reset;
      int rcnt, fv, fc;
      fv = -1; fc = -1;
      sync_psg("soft");
      soft_reset = 1'b1;
      tick();
      soft_reset = 1'b0;
      checks++; if (state !== 2'd2) begin errors++; $display("FAIL soft_enter_hold: got %0d want 2", state); end
      rcnt = (sys_rst === 1'b1) ? 1 : 0;
      for (int k = 2; k <= 20; k++) begin
         tick();
         if (sys_rst === 1'b1) rcnt++;
         if (k == 5) begin
            checks++; if (state !== 2'd3) begin errors++; $display("FAIL soft_run_again: got %0d want 3", state); end
         end
         if (ce_vdp === 1'b1 && fv < 0) fv = k;
         if (ce_cpu === 1'b1 && fc < 0) fc = k;
      end
      checks++; if (rcnt != 4) begin errors++; $display("FAIL soft_sys_rst_len: got %0d want 4", rcnt); end
      checks++; if (fv != 8) begin errors++; $display("FAIL soft_first_vdp: got %0d want 8", fv); end
      checks++; if (fc != 16) begin errors++; $display("FAIL soft_first_cpu: got %0d want 16", fc); end
   endtask

   task automatic test_soft_in_hold;
      sync_psg("hold");
      soft_reset = 1'b1;
      tick();                 // P+1: RESET_HOLD
      soft_reset = 1'b0;
      tick();                 // P+2
      soft_reset = 1'b1;
      tick();                 // P+3: hold count restarts
      soft_reset = 1'b0;
      tick(); tick();         // P+5
      checks++; if (state !== 2'd2) begin errors++; $display("FAIL hold_restart_p5: got %0d want 2", state); end
      tick();                 // P+6
      checks++; if (state !== 2'd2) begin errors++; $display("FAIL hold_restart_p6: got %0d want 2", state); end
      tick();                 // P+7
      checks++; if (state !== 2'd3) begin errors++; $display("FAIL hold_restart_p7: got %0d want 3", state); end
   endtask

   task automatic test_lock_glitch;
      int sys_low;
      sys_low = 0;
      rst = 1'b1; pll_locked = 1'b0;
      tick();
      pll_locked = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int e = 0; e <= 22; e++) begin
         tick();
         if (e == 6) pll_locked = 1'b0;
         if (e == 7) pll_locked = 1'b1;
         if (e < 22 && sys_rst !== 1'b1) sys_low++;
         if (e == 8 && state !== 2'd1) begin errors++; $display("FAIL glitch_e8: got %0d want 1", state); end
         if (e == 9 && state !== 2'd0) begin errors++; $display("FAIL glitch_e9: got %0d want 0", state); end
         if (e == 10 && state !== 2'd1) begin errors++; $display("FAIL glitch_e10: got %0d want 1", state); end
         if (e == 17 && state !== 2'd1) begin errors++; $display("FAIL glitch_e17: got %0d want 1", state); end
         if (e == 18 && state !== 2'd2) begin errors++; $display("FAIL glitch_e18: got %0d want 2", state); end
         if (e == 22 && state !== 2'd3) begin errors++; $display("FAIL glitch_e22: got %0d want 3", state); end
         if (e == 8 || e == 9 || e == 10 || e == 17 || e == 18 || e == 22) checks++;
      end
      checks++; if (sys_low != 0) begin errors++; $display("FAIL glitch_sys_rst_drop: got %0d low cycles want 0", sys_low); end
   endtask

   task automatic test_lock_loss_run;
      int run_e, fv;
      run_e = -1; fv = -1;
      tick(); tick();
      pll_locked = 1'b0;
      tick();                 // k
      tick();                 // k+1
      checks++; if (state !== 2'd3 || sys_rst !== 1'b0) begin errors++; $display("FAIL loss_k1: got state %0d sys_rst %b want 3/0", state, sys_rst); end
      soft_reset = 1'b1;
      tick();                 // k+2: lock loss beats soft_reset
      soft_reset = 1'b0;
      checks++; if (state !== 2'd0) begin errors++; $display("FAIL loss_state: got %0d want 0", state); end
      checks++; if (sys_rst !== 1'b1) begin errors++; $display("FAIL loss_sys_rst: got %b want 1", sys_rst); end
      checks++; if ({ce_vdp, ce_cpu, ce_psg} !== 3'b000) begin errors++; $display("FAIL loss_enables: got %b want 000", {ce_vdp, ce_cpu, ce_psg}); end
      pll_locked = 1'b1;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (state === 2'd3 && run_e < 0) run_e = k;
         if (ce_vdp === 1'b1 && fv < 0) fv = k;
      end
      checks++; if (run_e < 0 || fv - run_e != 3) begin errors++; $display("FAIL loss_recover_ph: got run %0d vdp %0d want vdp-run=3", run_e, fv); end
   endtask

   task automatic test_async_reset;
      int n;
      n = 0;
      tick();
      while (ce_vdp !== 1'b1 && n < 10) begin tick(); n++; end
      checks++; if (ce_vdp !== 1'b1) begin errors++; $display("FAIL async_sync_timeout: ce_vdp got %b want 1", ce_vdp); end
      #2;
      rst = 1'b1;
      #1;
      checks++; if (sys_rst !== 1'b1 || state !== 2'd0) begin errors++; $display("FAIL async_reset: got sys_rst %b state %0d want 1/0", sys_rst, state); end
      checks++; if ({ce_vdp, ce_cpu, ce_psg} !== 3'b000) begin errors++; $display("FAIL async_enables: got %b want 000", {ce_vdp, ce_cpu, ce_psg}); end
      tick();
      test_power_up("async_recover");
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst = 1'b1; pll_locked = 1'b0; soft_reset = 1'b0; pause = 1'b0;
      test_reset();
      test_power_up("powerup");
      test_pause();
      test_soft_reset();
      test_soft_in_hold();
      test_lock_loss_run();
      test_async_reset();
      test_lock_glitch();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
